// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one request/ack bus between an instruction-fetch port
// and a data port. A granted access owns the bus until bus_ack_i or until it
// has waited TIMEOUT_CYC cycles, after which it is aborted with timeout_o.
// Optional macro ARB_RR_EN: when defined, simultaneous requests alternate
// between the ports; when undefined, the data port always wins.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ce_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_data_o,
  output logic        i_stallreq_o,
  input  logic        d_ce_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  output logic [31:0] d_data_o,
  output logic        d_stallreq_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        timeout_o
);

  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IBUSY = 2'd1,
    S_DBUSY = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_done_i;
  logic        r_done_d;
  logic        r_timeout;
  logic [7:0]  r_wait_cnt;
  logic        r_bus_we;
  logic [3:0]  r_bus_sel;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_i_data;
  logic [31:0] r_d_data;

  logic        w_idle;
  logic        w_i_busy;
  logic        w_d_busy;
  logic        w_i_elig;
  logic        w_d_elig;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_tmo_hit;
  logic        w_bus_req;
  logic        w_i_stall;
  logic        w_d_stall;

  assign w_idle   = (r_state == S_IDLE);
  assign w_i_busy = (r_state == S_IBUSY);
  assign w_d_busy = (r_state == S_DBUSY);

  // A port that just completed sits out one cycle so its stall can drop
  assign w_i_elig = i_ce_i & ~r_done_i;
  assign w_d_elig = d_ce_i & ~r_done_d;

  // Abort only when the final wait cycle passes without an ack
  assign w_tmo_hit = (w_i_busy | w_d_busy) & ~bus_ack_i & (r_wait_cnt == LP_WAIT_LAST);

`ifdef ARB_RR_EN
  logic r_last_d;

  // Remember which port was granted last so contention alternates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end else if (w_grant_i) begin
      r_last_d <= 1'b0;
    end
  end

  assign w_grant_d = w_idle & w_d_elig & (~w_i_elig | ~r_last_d);
`else
  assign w_grant_d = w_idle & w_d_elig;
`endif
  assign w_grant_i = w_idle & w_i_elig & ~w_grant_d;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: grant from IDLE, leave BUSY on ack or timeout
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_next_state = S_DBUSY;
        end else if (w_grant_i) begin
          w_next_state = S_IBUSY;
        end
      end
      S_IBUSY, S_DBUSY: begin
        if (bus_ack_i || w_tmo_hit) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: bus request follows state, stalls follow request and done
  always_comb begin
    w_bus_req = w_i_busy | w_d_busy;
    w_i_stall = i_ce_i & ~r_done_i;
    w_d_stall = d_ce_i & ~r_done_d;
  end

  // Capture the winner's access so the bus stays stable while it is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_we    <= 1'b0;
      r_bus_sel   <= 4'h0;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
    end else if (w_grant_d) begin
      r_bus_we    <= d_we_i;
      r_bus_sel   <= d_sel_i;
      r_bus_addr  <= d_addr_i;
      r_bus_wdata <= d_data_i;
    end else if (w_grant_i) begin
      r_bus_we    <= 1'b0;
      r_bus_sel   <= 4'hf;
      r_bus_addr  <= i_addr_i;
      r_bus_wdata <= 32'h0;
    end
  end

  // Count unanswered busy cycles; restarts from zero for every access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 8'h0;
    end else if (w_idle) begin
      r_wait_cnt <= 8'h0;
    end else if (!bus_ack_i) begin
      r_wait_cnt <= r_wait_cnt + 8'h1;
    end
  end

  // One-cycle completion flags and timeout pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_i  <= 1'b0;
      r_done_d  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done_i  <= w_i_busy & (bus_ack_i | w_tmo_hit);
      r_done_d  <= w_d_busy & (bus_ack_i | w_tmo_hit);
      r_timeout <= w_tmo_hit;
    end
  end

  // Fetch result: bus word on ack, zero on abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_data <= 32'h0;
    end else if (w_i_busy && bus_ack_i) begin
      r_i_data <= bus_data_i;
    end else if (w_i_busy && w_tmo_hit) begin
      r_i_data <= 32'h0;
    end
  end

  // Load result: only reads update it; stores leave the last load intact
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_data <= 32'h0;
    end else if (w_d_busy && !r_bus_we && bus_ack_i) begin
      r_d_data <= bus_data_i;
    end else if (w_d_busy && !r_bus_we && w_tmo_hit) begin
      r_d_data <= 32'h0;
    end
  end

  assign bus_req_o    = w_bus_req;
  assign bus_we_o     = r_bus_we;
  assign bus_sel_o    = r_bus_sel;
  assign bus_addr_o   = r_bus_addr;
  assign bus_data_o   = r_bus_wdata;
  assign i_data_o     = r_i_data;
  assign d_data_o     = r_d_data;
  assign i_stallreq_o = w_i_stall;
  assign d_stallreq_o = w_d_stall;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        i_ce_i;
  logic [31:0] i_addr_i;
  logic [31:0] i_data_o;
  logic        i_stallreq_o;
  logic        d_ce_i;
  logic        d_we_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_data_i;
  logic [31:0] d_data_o;
  logic        d_stallreq_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;
  logic        timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_ce_i       (i_ce_i),
    .i_addr_i     (i_addr_i),
    .i_data_o     (i_data_o),
    .i_stallreq_o (i_stallreq_o),
    .d_ce_i       (d_ce_i),
    .d_we_i       (d_we_i),
    .d_sel_i      (d_sel_i),
    .d_addr_i     (d_addr_i),
    .d_data_i     (d_data_i),
    .d_data_o     (d_data_o),
    .d_stallreq_o (d_stallreq_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_sel_o    (bus_sel_o),
    .bus_addr_o   (bus_addr_o),
    .bus_data_o   (bus_data_o),
    .bus_data_i   (bus_data_i),
    .bus_ack_i    (bus_ack_i),
    .timeout_o    (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    i_ce_i     = 1'b0;
    i_addr_i   = 32'h0;
    d_ce_i     = 1'b0;
    d_we_i     = 1'b0;
    d_sel_i    = 4'h0;
    d_addr_i   = 32'h0;
    d_data_i   = 32'h0;
    bus_data_i = 32'h0;
    bus_ack_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [136:0] act;
    do_reset();
    @(negedge clk);
    act = {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, i_data_o, d_data_o,
           i_stallreq_o, d_stallreq_o, timeout_o};
    n_checks++;
    if (act !== 137'h0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", act);
    end
    // load i_data_o with a fetch so the mid-access reset has something to clear
    next_cycle();
    i_ce_i = 1'b1; i_addr_i = 32'h500;
    next_cycle();
    bus_ack_i = 1'b1; bus_data_i = 32'h0BADF00D;
    next_cycle();
    bus_ack_i = 1'b0; bus_data_i = 32'h0;
    i_ce_i = 1'b0; d_ce_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'hc;
    d_addr_i = 32'h600; d_data_i = 32'h13579BDF;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || i_data_o !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL reset_pre_dbusy: got req=%0b we=%0b idata=%h want 1 1 0badf00d",
                         bus_req_o, bus_we_o, i_data_o);
    end
    #2;
    i_ce_i = 1'b1;
    rst = 1'b1;
    #1;
    act = {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, i_data_o, d_data_o,
           i_stallreq_o, d_stallreq_o, timeout_o};
    n_checks++;
    if (act !== {135'h0, 2'b11, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid_access: got %h want %h", act, {135'h0, 2'b11, 1'b0});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_ce_i = 1'b1; i_addr_i = 32'h800;
    d_we_i = 1'b0; d_sel_i = 4'hf; d_addr_i = 32'h700;
    @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_idle: got req=%0b want 0", bus_req_o);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h700 || bus_we_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_fresh_req: got req=%0b addr=%h we=%0b want 1 00000700 0",
                         bus_req_o, bus_addr_o, bus_we_o);
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    i_ce_i = 1'b1; i_addr_i = 32'h100;
    @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b0 || i_stallreq_o !== 1'b1) begin
      n_fail++; $display("FAIL fetch_c0: got req=%0b stall=%0b want 0 1", bus_req_o, i_stallreq_o);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h100 || bus_we_o !== 1'b0 || bus_sel_o !== 4'hf) begin
      n_fail++; $display("FAIL fetch_bus: got req=%0b addr=%h we=%0b sel=%h want 1 00000100 0 f",
                         bus_req_o, bus_addr_o, bus_we_o, bus_sel_o);
    end
    next_cycle();
    next_cycle();
    next_cycle();
    bus_ack_i = 1'b1; bus_data_i = 32'h24010005;
    @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b1 || i_stallreq_o !== 1'b1) begin
      n_fail++; $display("FAIL fetch_ack_cycle: got req=%0b stall=%0b want 1 1", bus_req_o, i_stallreq_o);
    end
    next_cycle();
    bus_ack_i = 1'b0; bus_data_i = 32'h0;
    @(negedge clk);
    n_checks++;
    if (i_data_o !== 32'h24010005 || i_stallreq_o !== 1'b0 || bus_req_o !== 1'b0 || timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL fetch_done: got data=%h stall=%0b req=%0b tmo=%0b want 24010005 0 0 0",
                         i_data_o, i_stallreq_o, bus_req_o, timeout_o);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (i_stallreq_o !== 1'b1 || i_data_o !== 32'h24010005) begin
      n_fail++; $display("FAIL fetch_stall_back: got stall=%0b data=%h want 1 24010005",
                         i_stallreq_o, i_data_o);
    end
  endtask

  task automatic test_priority();
    do_reset();
    i_ce_i = 1'b1; i_addr_i = 32'h300;
    d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hf; d_addr_i = 32'h200;
    @(negedge clk);
    next_cycle();
    bus_ack_i = 1'b1; bus_data_i = 32'hAAAA5555;
    @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h200 || i_stallreq_o !== 1'b1) begin
      n_fail++; $display("FAIL prio_data_first: got req=%0b addr=%h istall=%0b want 1 00000200 1",
                         bus_req_o, bus_addr_o, i_stallreq_o);
    end
    next_cycle();
    bus_ack_i = 1'b0; bus_data_i = 32'h0; d_ce_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d_data_o !== 32'hAAAA5555 || bus_req_o !== 1'b0 || i_stallreq_o !== 1'b1 || d_stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL prio_data_done: got dd=%h req=%0b is=%0b ds=%0b want aaaa5555 0 1 0",
                         d_data_o, bus_req_o, i_stallreq_o, d_stallreq_o);
    end
    next_cycle();
    bus_ack_i = 1'b1; bus_data_i = 32'h11112222;
    @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h300 || bus_sel_o !== 4'hf || i_stallreq_o !== 1'b1) begin
      n_fail++; $display("FAIL prio_fetch_next: got req=%0b addr=%h sel=%h is=%0b want 1 00000300 f 1",
                         bus_req_o, bus_addr_o, bus_sel_o, i_stallreq_o);
    end
    next_cycle();
    bus_ack_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (i_data_o !== 32'h11112222 || i_stallreq_o !== 1'b0 || d_data_o !== 32'hAAAA5555) begin
      n_fail++; $display("FAIL prio_fetch_done: got id=%h is=%0b dd=%h want 11112222 0 aaaa5555",
                         i_data_o, i_stallreq_o, d_data_o);
    end
  endtask

  task automatic test_alternate();
    logic        exp_req;
    logic [31:0] exp_addr;
    do_reset();
    i_ce_i = 1'b1; i_addr_i = 32'h1000;
    d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hf; d_addr_i = 32'h2000;
    bus_ack_i = 1'b1; bus_data_i = 32'h99;
    for (int c = 0; c < 8; c++) begin
      if (c != 0) next_cycle();
      @(negedge clk);
      exp_req = c[0];
      n_checks++;
      if (bus_req_o !== exp_req) begin
        n_fail++; $display("FAIL alt_req_c%0d: got %0b want %0b", c, bus_req_o, exp_req);
      end
      if (exp_req) begin
        exp_addr = ((c % 4) == 1) ? 32'h2000 : 32'h1000;
        n_checks++;
        if (bus_addr_o !== exp_addr) begin
          n_fail++; $display("FAIL alt_owner_c%0d: got addr=%h want %h", c, bus_addr_o, exp_addr);
        end
      end
    end
  endtask

  task automatic test_store();
    do_reset();
    d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hf; d_addr_i = 32'h80;
    next_cycle();
    bus_ack_i = 1'b1; bus_data_i = 32'hCAFEF00D;
    next_cycle();
    bus_ack_i = 1'b0;
    d_we_i = 1'b1; d_sel_i = 4'b0011; d_addr_i = 32'h40; d_data_i = 32'h12345678;
    next_cycle();
    bus_data_i = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      if (c == 1) begin
        // ce and inputs change mid-access; the access must carry on unchanged
        d_ce_i = 1'b0; d_sel_i = 4'hf; d_addr_i = 32'h0; d_we_i = 1'b0;
      end
      if (c == 2) bus_ack_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || bus_sel_o !== 4'b0011 ||
          bus_addr_o !== 32'h40 || bus_data_o !== 32'h12345678) begin
        n_fail++; $display("FAIL store_bus_c%0d: got req=%0b we=%0b sel=%h addr=%h wd=%h want 1 1 3 00000040 12345678",
                           c, bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o);
      end
    end
    next_cycle();
    bus_ack_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d_data_o !== 32'hCAFEF00D || bus_req_o !== 1'b0 || d_stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL store_done: got dd=%h req=%0b ds=%0b want cafef00d 0 0",
                         d_data_o, bus_req_o, d_stallreq_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    d_ce_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hf; d_addr_i = 32'h10;
    next_cycle();
    bus_ack_i = 1'b1; bus_data_i = 32'h77778888;
    next_cycle();
    bus_ack_i = 1'b0; bus_data_i = 32'hFFFFFFFF; d_addr_i = 32'h44;
    next_cycle();
    for (int c = 0; c < TMO; c++) begin
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (bus_req_o !== 1'b1 || timeout_o !== 1'b0 || d_stallreq_o !== 1'b1) begin
        n_fail++; $display("FAIL tmo_wait_c%0d: got req=%0b tmo=%0b ds=%0b want 1 0 1",
                           c, bus_req_o, timeout_o, d_stallreq_o);
      end
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b0 || timeout_o !== 1'b1 || d_data_o !== 32'h0 || d_stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL tmo_abort: got req=%0b tmo=%0b dd=%h ds=%0b want 0 1 0 0",
                         bus_req_o, timeout_o, d_data_o, d_stallreq_o);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (timeout_o !== 1'b0 || d_stallreq_o !== 1'b1) begin
      n_fail++; $display("FAIL tmo_pulse_end: got tmo=%0b ds=%0b want 0 1", timeout_o, d_stallreq_o);
    end
    for (int c = 0; c < TMO; c++) begin
      next_cycle();
      if (c == TMO - 1) begin
        bus_ack_i = 1'b1; bus_data_i = 32'h31415926;
      end
    end
    next_cycle();
    bus_ack_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (timeout_o !== 1'b0 || d_data_o !== 32'h31415926 || bus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL tmo_late_ack: got tmo=%0b dd=%h req=%0b want 0 31415926 0",
                         timeout_o, d_data_o, bus_req_o);
    end
  endtask

  // Reference model: tracks the owner of the bus and how many busy cycles it
  // has waited; timeout means the TMO-th busy cycle passed with no ack.
  task automatic test_random();
    int           m_owner;   // 0 none, 1 fetch, 2 data
    int           m_age;
    logic         m_we;
    logic [3:0]   m_sel;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic         m_wdata_known;
    logic [31:0]  m_idata;
    logic [31:0]  m_ddata;
    logic         m_done_i;
    logic         m_done_d;
    logic         m_tmo;
    logic         m_last_d;
    logic         want_i;
    logic         want_d;
    logic         pick_d;
    logic         nd_i;
    logic         nd_d;
    logic         nt;
    logic [136:0] exp_v;
    logic [136:0] act_v;
    logic [136:0] mask;
    do_reset();
    m_owner = 0; m_age = 0; m_we = 1'b0; m_sel = 4'h0; m_addr = 32'h0;
    m_wdata = 32'h0; m_wdata_known = 1'b1; m_idata = 32'h0; m_ddata = 32'h0;
    m_done_i = 1'b0; m_done_d = 1'b0; m_tmo = 1'b0; m_last_d = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk);
        nd_i = 1'b0; nd_d = 1'b0; nt = 1'b0;
        if (m_owner == 0) begin
          want_i = i_ce_i && !m_done_i;
          want_d = d_ce_i && !m_done_d;
`ifdef ARB_RR_EN
          pick_d = want_d && (!want_i || !m_last_d);
`else
          pick_d = want_d;
`endif
          if (pick_d) begin
            m_owner = 2; m_age = 0; m_last_d = 1'b1;
            m_we = d_we_i; m_sel = d_sel_i; m_addr = d_addr_i;
            m_wdata = d_data_i; m_wdata_known = 1'b1;
          end else if (want_i) begin
            m_owner = 1; m_age = 0; m_last_d = 1'b0;
            m_we = 1'b0; m_sel = 4'hf; m_addr = i_addr_i; m_wdata_known = 1'b0;
          end
        end else if (bus_ack_i) begin
          if (m_owner == 1) begin
            m_idata = bus_data_i; nd_i = 1'b1;
          end else begin
            if (!m_we) m_ddata = bus_data_i;
            nd_d = 1'b1;
          end
          m_owner = 0;
        end else if (m_age + 1 == TMO) begin
          if (m_owner == 1) begin
            m_idata = 32'h0; nd_i = 1'b1;
          end else begin
            if (!m_we) m_ddata = 32'h0;
            nd_d = 1'b1;
          end
          nt = 1'b1;
          m_owner = 0;
        end else begin
          m_age++;
        end
        m_done_i = nd_i; m_done_d = nd_d; m_tmo = nt;
        #1;
      end
      i_ce_i     = ($urandom_range(0, 3) != 0);
      i_addr_i   = $urandom;
      d_ce_i     = ($urandom_range(0, 3) != 0);
      d_we_i     = $urandom_range(0, 1);
      d_sel_i    = 4'($urandom_range(0, 15));
      d_addr_i   = $urandom;
      d_data_i   = $urandom;
      bus_data_i = $urandom;
      bus_ack_i  = ($urandom_range(0, 9) < 3);
      @(negedge clk);
      act_v = {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, i_data_o, d_data_o,
               i_stallreq_o, d_stallreq_o, timeout_o};
      exp_v = {(m_owner != 0), m_we, m_sel, m_addr, m_wdata, m_idata, m_ddata,
               i_ce_i & ~m_done_i, d_ce_i & ~m_done_d, m_tmo};
      mask = '1;
      if (!m_wdata_known) mask[98:67] = 32'h0;
      n_checks++;
      if ((act_v & mask) !== (exp_v & mask)) begin
        n_fail++; $display("FAIL random_c%0d: got %h want %h", cyc, act_v & mask, exp_v & mask);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_alternate();
    test_store();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
